// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   Registered instruction-decode stage that sits between fetch and
//   register-file read. It decodes the opcode into a one-hot class vector,
//   extends the immediate, and derives the destination register, source
//   registers and write enable. A 2-entry skid buffer (output reg + skid reg)
//   provides full-throughput valid/ready flow control. The stage also supports
//   flush and keeps a saturating count of accepted illegal opcodes.
//
// Ports
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   flush        in   synchronous; discard held and incoming instructions
//   in_valid     in   fetch offers in_insn / in_pc
//   in_ready     out  stage can accept (registered, low only when skid full)
//   in_insn      in   instruction word
//   in_pc        in   PC of the instruction
//   out_valid    out  decoded bundle valid
//   out_ready    in   downstream accepts
//   out_pc       out  PC of the decoded instruction
//   out_class    out  one-hot {beq,setx,bex,jr,jal,j,blt,bne,lw,sw,addi,R}
//   out_illegal  out  opcode matched no class
//   out_aluop    out  ALU operation
//   out_shamt    out  shift amount insn[11:7]
//   out_imm      out  extended immediate
//   out_rd       out  destination register
//   out_we       out  register-file write enable
//   out_src_a    out  source register A
//   out_src_b    out  source register B
//   illegal_cnt  out  illegal opcodes accepted since reset (saturating)
//   dbg_state    out  skid-buffer state (0 EMPTY, 1 ONE, 2 FULL)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready never depends combinationally on out_ready, and the
// out_* bundle is held stable while out_valid is high and out_ready is low.
// ---------------------------------------------------------------------------
module decode_stage #(
  parameter int OPC_W  = 5,
  parameter int INSN_W = 32,
  parameter int XLEN   = 32,
  parameter int IMM_W  = 17,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INSN_W-1:0] in_insn,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [11:0]       out_class,
  output logic              out_illegal,
  output logic [4:0]        out_aluop,
  output logic [4:0]        out_shamt,
  output logic [XLEN-1:0]   out_imm,
  output logic [4:0]        out_rd,
  output logic              out_we,
  output logic [4:0]        out_src_a,
  output logic [4:0]        out_src_b,
  output logic [CNT_W-1:0]  illegal_cnt,
  output logic [1:0]        dbg_state
);

  localparam int TGT_W = INSN_W - OPC_W;  // jump-target / setx field width

  localparam logic [OPC_W-1:0] OP_R    = OPC_W'(5'b00000);
  localparam logic [OPC_W-1:0] OP_J    = OPC_W'(5'b00001);
  localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(5'b00010);
  localparam logic [OPC_W-1:0] OP_JAL  = OPC_W'(5'b00011);
  localparam logic [OPC_W-1:0] OP_JR   = OPC_W'(5'b00100);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5'b00101);
  localparam logic [OPC_W-1:0] OP_BLT  = OPC_W'(5'b00110);
  localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(5'b00111);
  localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(5'b01000);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(5'b01001);
  localparam logic [OPC_W-1:0] OP_SETX = OPC_W'(5'b10101);
  localparam logic [OPC_W-1:0] OP_BEX  = OPC_W'(5'b10110);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [11:0]     cls;
    logic            illegal;
    logic [4:0]      aluop;
    logic [4:0]      shamt;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            we;
    logic [4:0]      src_a;
    logic [4:0]      src_b;
  } bundle_t;

  state_e             state_q;
  bundle_t            or_q;
  bundle_t            sk_q;
  bundle_t            dec_d;
  logic               out_valid_q;
  logic               in_ready_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [OPC_W-1:0]   opc;
  logic [XLEN-1:0]    imm_sext;
  logic [XLEN-1:0]    imm_zext;
  logic               accept;
  logic               pop;

  assign opc      = in_insn[INSN_W-1 -: OPC_W];
  assign imm_sext = {{(XLEN-IMM_W){in_insn[IMM_W-1]}}, in_insn[IMM_W-1:0]};
  assign imm_zext = {{(XLEN-TGT_W){1'b0}}, in_insn[TGT_W-1:0]};

  // Combinational decode of the offered instruction.
  always_comb begin
    dec_d       = '0;
    dec_d.pc    = in_pc;
    dec_d.shamt = in_insn[11:7];
    dec_d.rd    = in_insn[26:22];
    dec_d.imm   = imm_sext;
    case (opc)
      OP_R: begin
        dec_d.cls[0] = 1'b1;
        dec_d.aluop  = in_insn[6:2];
        dec_d.we     = 1'b1;
        dec_d.src_a  = in_insn[21:17];
        dec_d.src_b  = in_insn[16:12];
      end
      OP_ADDI: begin
        dec_d.cls[1] = 1'b1;
        dec_d.we     = 1'b1;
        dec_d.src_a  = in_insn[21:17];
      end
      OP_SW: begin
        dec_d.cls[2] = 1'b1;
        dec_d.src_a  = in_insn[21:17];
        dec_d.src_b  = in_insn[26:22];  // store data comes from the rd field
      end
      OP_LW: begin
        dec_d.cls[3] = 1'b1;
        dec_d.we     = 1'b1;
        dec_d.src_a  = in_insn[21:17];
      end
      OP_BNE: begin
        dec_d.cls[4] = 1'b1;
        dec_d.aluop  = 5'b00001;
        dec_d.src_a  = in_insn[26:22];
        dec_d.src_b  = in_insn[21:17];
      end
      OP_BLT: begin
        dec_d.cls[5] = 1'b1;
        dec_d.aluop  = 5'b00001;
        dec_d.src_a  = in_insn[26:22];
        dec_d.src_b  = in_insn[21:17];
      end
      OP_J: begin
        dec_d.cls[6] = 1'b1;
        dec_d.imm    = imm_zext;
      end
      OP_JAL: begin
        dec_d.cls[7] = 1'b1;
        dec_d.imm    = imm_zext;
        dec_d.rd     = 5'd31;  // link register
        dec_d.we     = 1'b1;
      end
      OP_JR: begin
        dec_d.cls[8] = 1'b1;
        dec_d.src_a  = in_insn[26:22];
      end
      OP_BEX: begin
        dec_d.cls[9] = 1'b1;
        dec_d.aluop  = 5'b00001;
        dec_d.src_a  = 5'd30;  // compare status register against r0
      end
      OP_SETX: begin
        dec_d.cls[10] = 1'b1;
        dec_d.imm     = imm_zext;
        dec_d.rd      = 5'd30;  // status register
        dec_d.we      = 1'b1;
      end
      OP_BEQ: begin
        dec_d.cls[11] = 1'b1;
        dec_d.aluop   = 5'b00001;
        dec_d.src_a   = in_insn[26:22];
        dec_d.src_b   = in_insn[21:17];
      end
      default: dec_d.illegal = 1'b1;
    endcase
  end

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  // Skid-buffer FSM. OR always holds the oldest bundle; SK is only used when
  // a new bundle arrives while OR is stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      or_q        <= '0;
      sk_q        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      cnt_q       <= '0;
    end else if (flush) begin
      // Flush wins over every other event; the counter keeps its value.
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      if (accept && dec_d.illegal && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            or_q        <= dec_d;
            state_q     <= ST_ONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            or_q <= dec_d;
          end else if (accept) begin
            sk_q       <= dec_d;
            state_q    <= ST_FULL;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        ST_FULL: begin
          if (pop) begin
            or_q       <= sk_q;
            state_q    <= ST_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_pc      = or_q.pc;
  assign out_class   = or_q.cls;
  assign out_illegal = or_q.illegal;
  assign out_aluop   = or_q.aluop;
  assign out_shamt   = or_q.shamt;
  assign out_imm     = or_q.imm;
  assign out_rd      = or_q.rd;
  assign out_we      = or_q.we;
  assign out_src_a   = or_q.src_a;
  assign out_src_b   = or_q.src_b;
  assign illegal_cnt = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//   Directed bench for decode_stage: a decode vector table plus hand-written
//   sequences for streaming, stall/skid, counter saturation, flush and
//   asynchronous reset. A PC scoreboard checks ordering of every emitted
//   bundle.
// ---------------------------------------------------------------------------
module tb_decode_stage;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [11:0] out_class;
  logic        out_illegal;
  logic [4:0]  out_aluop;
  logic [4:0]  out_shamt;
  logic [31:0] out_imm;
  logic [4:0]  out_rd;
  logic        out_we;
  logic [4:0]  out_src_a;
  logic [4:0]  out_src_b;
  logic [7:0]  illegal_cnt;
  logic [1:0]  dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  decode_stage dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_insn     (in_insn),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_class   (out_class),
    .out_illegal (out_illegal),
    .out_aluop   (out_aluop),
    .out_shamt   (out_shamt),
    .out_imm     (out_imm),
    .out_rd      (out_rd),
    .out_we      (out_we),
    .out_src_a   (out_src_a),
    .out_src_b   (out_src_b),
    .illegal_cnt (illegal_cnt),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction encoders
  function automatic logic [31:0] i_type(input logic [4:0] opc, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [16:0] imm);
    return {opc, rd, rs, imm};
  endfunction

  function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] sh,
                                         input logic [4:0] op);
    return {5'b00000, rd, rs, rt, sh, op, 2'b00};
  endfunction

  function automatic logic [31:0] j_type(input logic [4:0] opc, input logic [26:0] t);
    return {opc, t};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One clock: score handshakes seen with the current inputs, then advance
  // to the next falling edge.
  task automatic tick();
    logic [31:0] e;
    if (out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: got pc 0x%0h expected no output", out_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_order", out_pc, e);
      end
    end
    if (in_valid && in_ready && !flush) exp_q.push_back(in_pc);
    if (flush) exp_q.delete();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_insn   = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic offer(input logic [31:0] insn, input logic [31:0] pc);
    in_valid = 1'b1;
    in_insn  = insn;
    in_pc    = pc;
  endtask

  typedef struct {
    logic [31:0] insn;
    logic [11:0] cls;
    logic        ill;
    logic [4:0]  aluop;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        we;
    logic [4:0]  sa;
    logic [4:0]  sb;
  } vec_t;

  vec_t vecs[13];

  initial begin
    // Decode table with hand-computed expectations.
    vecs[0]  = '{insn: i_type(5'b00101, 5'd1, 5'd2, 17'h1FFFB),           // addi r1,r2,-5
                 cls: 12'h002, ill: 0, aluop: 0, shamt: 31, imm: 32'hFFFFFFFB, rd: 1,  we: 1, sa: 2,  sb: 0};
    vecs[1]  = '{insn: r_type(5'd3, 5'd4, 5'd5, 5'd6, 5'd7),              // R
                 cls: 12'h001, ill: 0, aluop: 7, shamt: 6,  imm: 32'h0000531C, rd: 3,  we: 1, sa: 4,  sb: 5};
    vecs[2]  = '{insn: i_type(5'b00111, 5'd6, 5'd7, 17'h00010),           // sw
                 cls: 12'h004, ill: 0, aluop: 0, shamt: 0,  imm: 32'h00000010, rd: 6,  we: 0, sa: 7,  sb: 6};
    vecs[3]  = '{insn: i_type(5'b01000, 5'd8, 5'd9, 17'h10000),           // lw
                 cls: 12'h008, ill: 0, aluop: 0, shamt: 0,  imm: 32'hFFFF0000, rd: 8,  we: 1, sa: 9,  sb: 0};
    vecs[4]  = '{insn: i_type(5'b00010, 5'd10, 5'd11, 17'h00003),         // bne
                 cls: 12'h010, ill: 0, aluop: 1, shamt: 0,  imm: 32'h00000003, rd: 10, we: 0, sa: 10, sb: 11};
    vecs[5]  = '{insn: i_type(5'b00110, 5'd12, 5'd13, 17'h1FFFF),         // blt
                 cls: 12'h020, ill: 0, aluop: 1, shamt: 31, imm: 32'hFFFFFFFF, rd: 12, we: 0, sa: 12, sb: 13};
    vecs[6]  = '{insn: j_type(5'b00001, 27'h4000000),                     // j
                 cls: 12'h040, ill: 0, aluop: 0, shamt: 0,  imm: 32'h04000000, rd: 16, we: 0, sa: 0,  sb: 0};
    vecs[7]  = '{insn: j_type(5'b00011, 27'h0000123),                     // jal
                 cls: 12'h080, ill: 0, aluop: 0, shamt: 2,  imm: 32'h00000123, rd: 31, we: 1, sa: 0,  sb: 0};
    vecs[8]  = '{insn: i_type(5'b00100, 5'd15, 5'd0, 17'h00000),          // jr
                 cls: 12'h100, ill: 0, aluop: 0, shamt: 0,  imm: 32'h00000000, rd: 15, we: 0, sa: 15, sb: 0};
    vecs[9]  = '{insn: j_type(5'b10110, 27'h0000080),                     // bex
                 cls: 12'h200, ill: 0, aluop: 1, shamt: 1,  imm: 32'h00000080, rd: 0,  we: 0, sa: 30, sb: 0};
    vecs[10] = '{insn: j_type(5'b10101, 27'h0000007),                     // setx
                 cls: 12'h400, ill: 0, aluop: 0, shamt: 0,  imm: 32'h00000007, rd: 30, we: 1, sa: 0,  sb: 0};
    vecs[11] = '{insn: i_type(5'b01001, 5'd1, 5'd2, 17'h00100),           // beq
                 cls: 12'h800, ill: 0, aluop: 1, shamt: 2,  imm: 32'h00000100, rd: 1,  we: 0, sa: 1,  sb: 2};
    vecs[12] = '{insn: j_type(5'b11111, 27'h0000000),                     // illegal
                 cls: 12'h000, ill: 1, aluop: 0, shamt: 0,  imm: 32'h00000000, rd: 0,  we: 0, sa: 0,  sb: 0};

    do_reset();

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cnt", illegal_cnt, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_class", out_class, 0);
    chk("rst_state", dbg_state, 0);

    // Decode table, one instruction at a time with the sink ready
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      offer(vecs[i].insn, 32'h100 + 32'(i * 4));
      tick();
      in_valid = 1'b0;
      chk("tbl_valid", out_valid, 1);
      chk("tbl_pc", out_pc, 32'h100 + 32'(i * 4));
      chk("tbl_class", out_class, vecs[i].cls);
      chk("tbl_illegal", out_illegal, vecs[i].ill);
      chk("tbl_aluop", out_aluop, vecs[i].aluop);
      chk("tbl_shamt", out_shamt, vecs[i].shamt);
      chk("tbl_imm", out_imm, vecs[i].imm);
      chk("tbl_rd", out_rd, vecs[i].rd);
      chk("tbl_we", out_we, vecs[i].we);
      chk("tbl_src_a", out_src_a, vecs[i].sa);
      chk("tbl_src_b", out_src_b, vecs[i].sb);
      tick();
      chk("tbl_drained", out_valid, 0);
    end
    chk("tbl_cnt", illegal_cnt, 1);

    // Back-to-back jal then setx, no bubble
    offer(j_type(5'b00011, 27'h123), 32'h200);
    tick();
    chk("b2b_jal_valid", out_valid, 1);
    chk("b2b_jal_rd", out_rd, 31);
    chk("b2b_jal_imm", out_imm, 32'h123);
    chk("b2b_jal_we", out_we, 1);
    offer(j_type(5'b10101, 27'h7), 32'h204);
    tick();
    in_valid = 1'b0;
    chk("b2b_setx_valid", out_valid, 1);
    chk("b2b_setx_pc", out_pc, 32'h204);
    chk("b2b_setx_rd", out_rd, 30);
    chk("b2b_setx_imm", out_imm, 32'h7);
    chk("b2b_setx_we", out_we, 1);
    tick();
    chk("b2b_empty", out_valid, 0);

    // Stall: three offers with the sink blocked, two accepted
    out_ready = 1'b0;
    offer(vecs[0].insn, 32'h300);
    tick();
    chk("stall_rdy1", in_ready, 1);
    chk("stall_pc1", out_pc, 32'h300);
    offer(vecs[1].insn, 32'h304);
    tick();
    chk("stall_rdy_full", in_ready, 0);
    chk("stall_state_full", dbg_state, 2);
    offer(vecs[2].insn, 32'h308);
    tick();
    chk("stall_hold_pc", out_pc, 32'h300);
    chk("stall_hold_class", out_class, 12'h002);
    chk("stall_hold_imm", out_imm, 32'hFFFFFFFB);
    chk("stall_hold_rdy", in_ready, 0);
    out_ready = 1'b1;
    tick();
    chk("rel_pc2", out_pc, 32'h304);
    chk("rel_class2", out_class, 12'h001);
    chk("rel_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("rel_pc3", out_pc, 32'h308);
    chk("rel_class3", out_class, 12'h004);
    tick();
    chk("rel_empty", out_valid, 0);
    chk("rel_sb_empty", exp_q.size(), 0);

    // Illegal-opcode counter saturation
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      offer(j_type(5'b11111, 27'(i)), 32'h1000 + 32'(i * 4));
      tick();
      if (i == 253) chk("sat_cnt_254", illegal_cnt, 254);
      if (i == 254) chk("sat_cnt_255", illegal_cnt, 255);
    end
    in_valid = 1'b0;
    chk("sat_cnt_hold", illegal_cnt, 255);
    chk("sat_illegal", out_illegal, 1);
    chk("sat_class", out_class, 0);
    tick();
    chk("sat_empty", out_valid, 0);

    // Flush while FULL, with an illegal instruction offered in the same cycle
    do_reset();
    offer(vecs[0].insn, 32'h500);
    tick();
    offer(vecs[1].insn, 32'h504);
    tick();
    chk("fl_full", dbg_state, 2);
    flush = 1'b1;
    offer(vecs[12].insn, 32'h508);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_cnt", illegal_cnt, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_emit", out_valid, 0);
    end

    // Asynchronous reset while FULL
    do_reset();
    offer(vecs[12].insn, 32'h600);
    tick();
    offer(vecs[0].insn, 32'h604);
    tick();
    in_valid = 1'b0;
    chk("ar_full", dbg_state, 2);
    chk("ar_cnt_pre", illegal_cnt, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_cnt", illegal_cnt, 0);
    chk("ar_pc", out_pc, 0);
    chk("ar_illegal", out_illegal, 0);
    chk("ar_class", out_class, 0);
    chk("ar_state", dbg_state, 0);
    exp_q.delete();
    @(negedge clock);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    offer(vecs[0].insn, 32'h700);
    tick();
    in_valid = 1'b0;
    chk("ar_post_valid", out_valid, 1);
    chk("ar_post_pc", out_pc, 32'h700);
    chk("ar_post_rd", out_rd, 1);
    chk("ar_post_imm", out_imm, 32'hFFFFFFFB);
    tick();
    chk("ar_post_empty", out_valid, 0);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
